// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
// Holds the stall encodings, FSM states and the default exception vector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EXWAIT = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  // Stall bit order: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam logic [5:0] STALL_NONE    = 6'b000000;
  localparam logic [5:0] STALL_LOADUSE = 6'b000111;
  localparam logic [5:0] STALL_EX      = 6'b001111;

  localparam logic [31:0] EXCP_VEC_DEFAULT = 32'h0000_0100;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard requests from the pipeline and the controller's
// stall/flush/redirect responses.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        ex_done;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        excp_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        timeout_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output stallreq_id, stallreq_ex, ex_done, branch_flag_i, branch_target_i, excp_i,
    input  stall_o, flush_o, new_pc_o, timeout_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_id, stallreq_ex, ex_done, branch_flag_i, branch_target_i, excp_i,
    output stall_o, flush_o, new_pc_o, timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_stall_counter.sv
// 32-bit saturating event counter with synchronous clear; counts cycles
// in which enable is high.
module stall_counter
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (enable)
      count <= sat_inc(count);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates load-use stalls, multi-cycle execute waits,
// branch redirects and exceptions into per-stage stall and flush controls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXCP_VEC = EXCP_VEC_DEFAULT,
  parameter int          MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Exceptions win everywhere; FLUSH ignores requests from squashed instructions
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    stall   = STALL_NONE;
    flush   = 1'b0;
    new_pc  = '0;
    timeout = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.excp_i) begin
          flush   = 1'b1;
          new_pc  = EXCP_VEC;
          state_d = ST_FLUSH;
        end else if (bus.branch_flag_i) begin
          flush   = 1'b1;
          new_pc  = bus.branch_target_i;
          state_d = ST_FLUSH;
        end else if (bus.stallreq_ex) begin
          stall   = STALL_EX;
          state_d = ST_EXWAIT;
        end else if (bus.stallreq_id) begin
          stall   = STALL_LOADUSE;
        end
      end

      ST_EXWAIT: begin
        if (bus.excp_i) begin
          flush   = 1'b1;
          new_pc  = EXCP_VEC;
          state_d = ST_FLUSH;
        end else if (bus.ex_done) begin
          state_d = ST_RUN;
        end else if (wait_q == WAIT_LAST) begin
          timeout = 1'b1;
          flush   = 1'b1;
          new_pc  = EXCP_VEC;
          state_d = ST_FLUSH;
        end else begin
          stall   = STALL_EX;
          wait_d  = wait_q + 8'd1;
        end
      end

      ST_FLUSH: begin
        if (bus.excp_i) begin
          flush   = 1'b1;
          new_pc  = EXCP_VEC;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase

    if (rst) begin
      stall   = STALL_NONE;
      flush   = 1'b0;
      new_pc  = '0;
      timeout = 1'b0;
    end
  end

  assign bus.stall_o   = stall;
  assign bus.flush_o   = flush;
  assign bus.new_pc_o  = new_pc;
  assign bus.timeout_o = timeout;

  stall_counter u_stall_counter (
    .clk    (clk),
    .rst    (rst),
    .enable (stall != STALL_NONE),
    .count  (bus.stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios followed by random traffic,
// all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam logic [31:0] EXCP = 32'h0000_0100;
  localparam int          MAXW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.EXCP_VEC(EXCP), .MAX_WAIT(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: whether an execute wait is in progress, how many wait cycles
  // have elapsed, whether the previous cycle redirected, and total stalls.
  bit      m_waiting = 0;
  int      m_wait_cycles = 0;
  bit      m_after_flush = 0;
  longint  m_stall_total = 0;

  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_pc;
  logic        e_to;
  bit          nx_wait, nx_flush;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_outputs(input bit r_rst, input bit id, input bit ex, input bit done,
                               input bit br, input logic [31:0] tgt, input bit excp);
    e_stall = '0; e_flush = 0; e_pc = '0; e_to = 0; nx_wait = 0; nx_flush = 0;
    if (r_rst) return;
    if (excp) begin
      e_flush = 1; e_pc = EXCP; nx_flush = 1;
    end else if (m_waiting) begin
      if (!done) begin
        if (m_wait_cycles + 1 == MAXW) begin
          e_to = 1; e_flush = 1; e_pc = EXCP; nx_flush = 1;
        end else begin
          e_stall = 6'b001111; nx_wait = 1;
        end
      end
    end else if (!m_after_flush) begin
      if (br) begin
        e_flush = 1; e_pc = tgt; nx_flush = 1;
      end else if (ex) begin
        e_stall = 6'b001111; nx_wait = 1;
      end else if (id) begin
        e_stall = 6'b000111;
      end
    end
  endtask

  task automatic model_advance(input bit r_rst);
    if (r_rst) begin
      m_waiting = 0; m_wait_cycles = 0; m_after_flush = 0; m_stall_total = 0;
      return;
    end
    if (e_stall != 0 && m_stall_total < 64'hFFFF_FFFF) m_stall_total++;
    m_wait_cycles = (nx_wait && m_waiting) ? m_wait_cycles + 1 : 0;
    m_waiting     = nx_wait;
    m_after_flush = nx_flush;
  endtask

  // One clock cycle: drive, compare combinational outputs mid-cycle,
  // clock, then compare the registered stall count.
  task automatic apply_stimulus(input bit r_rst, input bit id, input bit ex, input bit done,
                                input bit br, input logic [31:0] tgt, input bit excp);
    rst                 = r_rst;
    bus.stallreq_id     = id;
    bus.stallreq_ex     = ex;
    bus.ex_done         = done;
    bus.branch_flag_i   = br;
    bus.branch_target_i = tgt;
    bus.excp_i          = excp;
    #4;
    model_outputs(r_rst, id, ex, done, br, tgt, excp);
    check_output("stall_o",   32'(bus.stall_o),   32'(e_stall));
    check_output("flush_o",   32'(bus.flush_o),   32'(e_flush));
    check_output("new_pc_o",  bus.new_pc_o,       e_pc);
    check_output("timeout_o", 32'(bus.timeout_o), 32'(e_to));
    @(posedge clk);
    #1;
    model_advance(r_rst);
    check_output("stall_cnt_o", bus.stall_cnt_o, 32'(m_stall_total));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    $display("[TB] start");
    bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.ex_done = 0;
    bus.branch_flag_i = 0; bus.branch_target_i = '0; bus.excp_i = 0;

    // Reset with noisy inputs, which must be ignored
    apply_stimulus(1, 1, 1, 0, 1, 32'hDEAD_BEEF, 1);
    apply_stimulus(1, 0, 0, 0, 0, '0, 0);
    idle(2);

    // Single load-use bubble
    apply_stimulus(0, 1, 0, 0, 0, '0, 0);
    idle(1);

    // Multi-cycle execute completing after five stall cycles
    apply_stimulus(0, 0, 1, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 0, 1, 32'h1234, 0);
    apply_stimulus(0, 1, 1, 1, 0, '0, 0);
    idle(1);

    // Branch redirect, then a squashed load-use request
    apply_stimulus(0, 1, 1, 0, 1, 32'h0000_2000, 0);
    apply_stimulus(0, 1, 1, 0, 1, 32'h0000_3000, 0);
    idle(1);

    // Execute timeout on the 64th wait cycle
    apply_stimulus(0, 0, 1, 0, 0, '0, 0);
    idle(MAXW + 2);

    // Exception and done in the same wait cycle
    apply_stimulus(0, 0, 1, 0, 0, '0, 0);
    idle(2);
    apply_stimulus(0, 0, 0, 1, 0, '0, 1);
    apply_stimulus(0, 0, 0, 0, 0, '0, 1);
    idle(2);

    // Reset in the middle of a wait
    apply_stimulus(0, 0, 1, 0, 0, '0, 0);
    idle(3);
    apply_stimulus(1, 0, 0, 0, 0, '0, 0);
    idle(3);

    // Random traffic, with rare done so some waits time out
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(($urandom_range(0, 399) == 0),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 7) == 0),
                     $urandom,
                     ($urandom_range(0, 59) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter EXCP_VEC, default 32'h0000_0100: exception/timeout redirect address.
REQ-002 Parameter MAX_WAIT, default 64: maximum number of EXWAIT cycles before timeout; legal range 2..255.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 stallreq_id  in  1  load-use hazard from decode, combinational, same cycle.
REQ-006 stallreq_ex  in  1  execute starting a multi-cycle operation.
REQ-007 ex_done  in  1  multi-cycle operation result valid this cycle.
REQ-008 branch_flag_i  in  1  taken branch/jump resolved in execute.
REQ-009 branch_target_i  in  32  branch destination.
REQ-010 excp_i  in  1  exception request.
REQ-011 stall_o  out  6  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-012 flush_o  out  1  clear IF/ID/EX pipeline registers at the next edge.
REQ-013 new_pc_o  out  32  redirect address; valid only while flush_o=1, else 0.
REQ-014 timeout_o  out  1  one-cycle pulse: EXWAIT exceeded MAX_WAIT.
REQ-015 stall_cnt_o  out  32  count of cycles with stall_o!=0, saturating at 32'hFFFF_FFFF.

Function
REQ-016 FSM states: RUN, EXWAIT, FLUSH; state and counters registered; stall_o, flush_o, new_pc_o combinational from state and inputs.
REQ-017 Priority within a cycle: excp_i > timeout > branch_flag_i > stallreq_ex > stallreq_id.
REQ-018 RUN, excp_i=1: flush_o=1, new_pc_o=EXCP_VEC, stall_o=0; next FLUSH.
REQ-019 RUN, branch_flag_i=1: flush_o=1, new_pc_o=branch_target_i, stall_o=0; next FLUSH.
REQ-020 RUN, stallreq_ex=1: stall_o=6'b001111; wait counter cleared; next EXWAIT.
REQ-021 RUN, stallreq_id=1 only: stall_o=6'b000111 for that cycle only; remain RUN (one bubble per assertion).
REQ-022 RUN, no request: stall_o=0, flush_o=0.
REQ-023 EXWAIT: stall_o=6'b001111 while ex_done=0; wait counter increments each cycle.
REQ-024 EXWAIT, ex_done=1: stall_o=0 that cycle; next RUN; same-cycle stallreq_id/stallreq_ex ignored.
REQ-025 EXWAIT: branch_flag_i and stallreq_id ignored.
REQ-026 EXWAIT, counter=MAX_WAIT-1 and ex_done=0: timeout_o=1, flush_o=1, new_pc_o=EXCP_VEC, stall_o=0; next FLUSH.
REQ-027 EXWAIT, excp_i=1: abort wait; flush_o=1, new_pc_o=EXCP_VEC; next FLUSH; excp_i wins over simultaneous ex_done.
REQ-028 FLUSH (one cycle): stall_o=0, flush_o=0; stallreq_id, stallreq_ex, branch_flag_i ignored (from squashed instructions); excp_i handled as in REQ-018; else next RUN.
REQ-029 stall_cnt_o increments at each edge where stall_o!=0; holds at saturation.
REQ-030 Wait counter 8 bits; cleared on entry to EXWAIT and in every other state.

Reset
REQ-031 rst=1 at a rising edge: state=RUN, wait counter=0, stall_cnt_o=0.
REQ-032 While rst=1: stall_o=0, flush_o=0, new_pc_o=0, timeout_o=0, all inputs ignored.
REQ-033 rst in EXWAIT or FLUSH: abandon the operation; after deassertion resume from RUN, no pending stall or flush.

Structure
REQ-034 Stall encodings (STALL_NONE, STALL_LOADUSE=6'b000111, STALL_EX=6'b001111), state encodings and EXCP_VEC default in the shared define file.
REQ-035 Single module; one sub-module, stall_counter (32-bit saturating counter, enable input), is natural.

Verification
REQ-036 RUN, stallreq_id=1 for 1 cycle -> stall_o=6'b000111 that cycle, 0 the next; stall_cnt_o +1.
REQ-037 stallreq_ex=1, ex_done after 5 cycles -> stall_o=6'b001111 for 5 cycles, 0 on the done cycle, state RUN; stall_cnt_o +5.
REQ-038 branch_flag_i=1, target 32'h0000_2000 -> flush_o=1, new_pc_o=32'h0000_2000 same cycle; next cycle stallreq_id=1 -> stall_o=0.
REQ-039 EXWAIT, ex_done never asserted, MAX_WAIT=64 -> timeout_o=1, flush_o=1, new_pc_o=32'h0000_0100 on the 64th EXWAIT cycle.
REQ-040 EXWAIT with excp_i=1 and ex_done=1 in the same cycle -> flush_o=1, new_pc_o=EXCP_VEC; next state FLUSH.
REQ-041 rst=1 mid-EXWAIT -> next cycle stall_o=0, stall_cnt_o=0; no flush after deassertion.
